gate_reduce_pipe: RTL and testbench

GATE_REDUCE_PIPE -- requirements
Module: gate_reduce_pipe

---
 rtl/gate_reduce_pkg.sv | 22 ++
 rtl/gate_reduce_lane.sv | 33 +++
 rtl/gate_reduce_pipe.sv | 98 +++++++++
 tb/tb_gate_reduce_pipe.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gate_reduce_pkg.sv
// Shared types for the gate reduction pipeline: operator encoding and
// the per-operator identity used to neutralise masked-out operands.
package gate_reduce_pkg;

    typedef enum logic [2:0] {
        GM_AND  = 3'd0,
        GM_OR   = 3'd1,
        GM_XOR  = 3'd2,
        GM_NAND = 3'd3,
        GM_NOR  = 3'd4,
        GM_XNOR = 3'd5
    } gate_mode_t;

    // Operand value that leaves the underlying AND/OR/XOR reduction unchanged.
    function automatic logic gate_identity(input gate_mode_t mode);
        case (mode)
            GM_AND, GM_NAND: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gate_reduce_lane.sv
// Combinational NIN-bit reduction of one channel under a per-operand mask.
module gate_reduce_lane
    import gate_reduce_pkg::*;
#(
    parameter int NIN = 5
) (
    input  logic [NIN-1:0] i_data,
    input  logic [NIN-1:0] i_mask,
    input  gate_mode_t     i_mode,
    output logic           o_res
);

    logic           w_fill;
    logic [NIN-1:0] w_ops;

    assign w_fill = gate_identity(i_mode);
    // AND-ing with the mask keeps X/Z on ignored operands out of the result.
    assign w_ops  = (i_data & i_mask) | (~i_mask & {NIN{w_fill}});

    always_comb begin
        o_res = 1'b0;
        case (i_mode)
            GM_AND:  o_res =  (&w_ops);
            GM_OR:   o_res =  (|w_ops);
            GM_XOR:  o_res =  (^w_ops);
            GM_NAND: o_res = ~(&w_ops);
            GM_NOR:  o_res = ~(|w_ops);
            GM_XNOR: o_res = ~(^w_ops);
            default: o_res = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_reduce_pipe.sv
// Two-stage valid/ready pipeline of NCH masked gate reductions.
// Optional saturating output-transfer counter enabled by GATE_REDUCE_PIPE_CNT_EN.
module gate_reduce_pipe
    import gate_reduce_pkg::*;
#(
    parameter int NCH = 6,
    parameter int NIN = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*NIN-1:0]   in_data,
    input  logic [NCH*NIN-1:0]   in_mask,
    input  logic [2:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH-1:0]       out_data
`ifdef GATE_REDUCE_PIPE_CNT_EN
    ,
    output logic [15:0]          out_count
`endif
);

    logic               r_s1_vld;
    logic [NCH*NIN-1:0] r_s1_data;
    logic [NCH*NIN-1:0] r_s1_mask;
    gate_mode_t         r_s1_mode;
    logic               r_s2_vld;
    logic [NCH-1:0]     r_s2_res;

    logic               w_s1_load;
    logic               w_s2_load;
    logic [NCH-1:0]     w_res;

    // S2 frees up when empty or when its result leaves this cycle.
    assign w_s2_load = r_s1_vld & (~r_s2_vld | out_ready);
    assign in_ready  = ~rst & (~r_s1_vld | w_s2_load);
    assign w_s1_load = in_valid & in_ready;

    assign out_valid = r_s2_vld;
    assign out_data  = r_s2_res;

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_lane
            gate_reduce_lane #(.NIN(NIN)) u_lane (
                .i_data (r_s1_data[c*NIN +: NIN]),
                .i_mask (r_s1_mask[c*NIN +: NIN]),
                .i_mode (r_s1_mode),
                .o_res  (w_res[c])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s2_res <= '0;
        end else begin
            if (w_s1_load)
                r_s1_vld <= 1'b1;
            else if (w_s2_load)
                r_s1_vld <= 1'b0;

            if (w_s2_load) begin
                r_s2_vld <= 1'b1;
                r_s2_res <= w_res;
            end else if (out_ready) begin
                r_s2_vld <= 1'b0;
            end
        end
    end

    // Payload registers need no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_s1_load) begin
            r_s1_data <= in_data;
            r_s1_mask <= in_mask;
            r_s1_mode <= gate_mode_t'(in_mode);
        end
    end

`ifdef GATE_REDUCE_PIPE_CNT_EN
    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (out_valid && out_ready && r_count != 16'hFFFF)
            r_count <= r_count + 16'd1;
    end

    assign out_count = r_count;
`endif

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// Directed bench for gate_reduce_pipe: operators, masks, stall/order, reset flush.
module tb_gate_reduce_pipe;

    localparam int NCH = 6;
    localparam int NIN = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*NIN-1:0]   in_data;
    logic [NCH*NIN-1:0]   in_mask;
    logic [2:0]           in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [NCH-1:0]       out_data;
`ifdef GATE_REDUCE_PIPE_CNT_EN
    logic [15:0]          out_count;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gate_reduce_pipe #(.NCH(NCH), .NIN(NIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef GATE_REDUCE_PIPE_CNT_EN
        ,
        .out_count (out_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic push(input logic [NCH*NIN-1:0] d, input logic [NCH*NIN-1:0] m,
                        input logic [2:0] md);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = m;
        in_mode  = md;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("push_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run1(input string tag, input logic [NCH*NIN-1:0] d,
                        input logic [NCH*NIN-1:0] m, input logic [2:0] md,
                        input logic [NCH-1:0] exp);
        push(d, m, md);
        chk({tag, "_lat_early"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, {26'd0, out_data}, {26'd0, exp});
    endtask

    logic [NCH-1:0]     exp_q [10];
    logic [NCH*NIN-1:0] req_d [10];
    int idx, got, cyc;
    logic acc, drn, seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; in_mode = 3'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {26'd0, out_data}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Channels packed {ch5,ch4,ch3,ch2,ch1,ch0}.
        run1("and", {5'b01000, 5'b00000, 5'b11111, 5'b10101, 5'b00000, 5'b11111},
                    {5'b01000, 5'b00000, 5'b11111, 5'b11111, 5'b00001, 5'b00111},
                    3'd0, 6'b111001);
        run1("nor_nomask", {30{1'b1}}, '0, 3'd4, 6'b111111);
        run1("xor", {5'b11100, 5'b00000, 5'b11111, 5'b10110, 5'b00111, 5'b00011},
                    {5'b01100, 5'b00000, 5'b10000, 5'b11111, 5'b00011, 5'b11111},
                    3'd2, 6'b001100);
        run1("or",  {5'b00001, 5'b00000, 5'b11111, 5'b11111, 5'b00100, 5'b10000},
                    {5'b11111, 5'b11111, 5'b11111, 5'b00000, 5'b00100, 5'b01111},
                    3'd1, 6'b101010);
        run1("nand", {5'b10111, 5'b11110, 5'b11111, 5'b00000, 5'b01000, 5'b11111},
                     {5'b10111, 5'b11111, 5'b11111, 5'b00010, 5'b01000, 5'b00000},
                     3'd3, 6'b010100);
        run1("xnor", {5'b11111, 5'b10101, 5'b11000, 5'b00000, 5'b00001, 5'b11111},
                     {5'b00111, 5'b11111, 5'b11111, 5'b00100, 5'b00001, 5'b00000},
                     3'd5, 6'b001101);
        run1("nor", {5'b11111, 5'b11111, 5'b11111, 5'b00010, 5'b00100, 5'b00000},
                    {5'b00000, 5'b00000, 5'b00000, 5'b11101, 5'b00100, 5'b11111},
                    3'd4, 6'b111101);
        run1("mode7", {30{1'b1}}, {30{1'b1}}, 3'd7, 6'b000000);
        run1("mode6", {30{1'b1}}, {30{1'b1}}, 3'd6, 6'b000000);
        run1("and_x", {6{5'b1x1x1}}, {6{5'b10101}}, 3'd0, 6'b111111);
        run1("or_x",  {6{5'b0x0x0}}, {6{5'b10101}}, 3'd1, 6'b000000);

        // Stall: ten OR requests whose results equal a per-request pattern.
        for (int i = 0; i < 10; i++) begin
            exp_q[i] = 6'(i * 7 + 3);
            req_d[i] = '0;
            for (int c = 0; c < NCH; c++) req_d[i][c*NIN] = exp_q[i][c];
        end
        idx = 0; got = 0; cyc = 0;
        @(negedge clk);
        while (got < 10 && cyc < 200) begin
            cyc++;
            out_ready = (cyc > 6);
            in_valid  = (idx < 10);
            in_data   = (idx < 10) ? req_d[idx] : '0;
            in_mask   = {30{1'b1}};
            in_mode   = 3'd1;
            #1;
            if (cyc >= 3 && cyc <= 6) begin
                chk("stall_hold_vld", {31'd0, out_valid}, 32'd1);
                chk("stall_hold_data", {26'd0, out_data}, {26'd0, exp_q[0]});
            end
            if (cyc == 6) begin
                chk("stall_accepted", idx, 32'd2);
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            end
            acc = in_valid & in_ready;
            drn = out_valid & out_ready;
            if (drn) begin
                chk("order_data", {26'd0, out_data}, {26'd0, exp_q[got]});
                got++;
            end
            if (acc) idx++;
            @(negedge clk);
        end
        chk("stall_all_delivered", got, 32'd10);
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_drained", {31'd0, out_valid}, 32'd0);

        // Reset with two requests in flight.
        out_ready = 1'b0;
        push({30{1'b1}}, {30{1'b1}}, 3'd0);
        push({30{1'b1}}, {30{1'b1}}, 3'd0);
        chk("pre_rst_vld", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {26'd0, out_data}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("no_stale_result", {31'd0, seen}, 32'd0);

`ifdef GATE_REDUCE_PIPE_CNT_EN
        in_valid = 1'b1; in_data = '0; in_mask = '0; in_mode = 3'd0;
        out_ready = 1'b1;
        repeat (70010) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("count_sat", {16'd0, out_count}, 32'h0000FFFF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("count_rst", {16'd0, out_count}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
